// File: rtl/stream_cut_pkg.sv
// Shared helpers for the stream_cut_fifo pointer arithmetic.
// Pointers carry one extra wrap bit above the address bits, so full and
// empty are told apart by whether the wrap bits differ.
package stream_cut_pkg;

    // Full: address bits equal, wrap (top) bit different.
    // Pointers are passed zero-extended to 32 bits with their real width.
    function automatic logic ptr_full(input logic [31:0] wr,
                                      input logic [31:0] rd,
                                      input int unsigned ptr_width);
        logic [31:0] diff;
        diff = (wr ^ rd) & ((32'd1 << ptr_width) - 32'd1);
        return diff == (32'd1 << (ptr_width - 1));
    endfunction

    // Empty: both pointers identical, including the wrap bit.
    function automatic logic ptr_empty(input logic [31:0] wr,
                                       input logic [31:0] rd,
                                       input int unsigned ptr_width);
        logic [31:0] diff;
        diff = (wr ^ rd) & ((32'd1 << ptr_width) - 32'd1);
        return diff == 32'd0;
    endfunction

endpackage

// File: rtl/stream_cut_ptr.sv
// Wrapping queue pointer: counter with enable and synchronous clear.
// It counts modulo 2^Width, so the top bit acts as the wrap flag.
module stream_cut_ptr #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] ptr_o
);

    logic [Width-1:0] ptr_d;
    logic [Width-1:0] ptr_q;

    // Next pointer value: a clear wins over an increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_cut_fifo.sv
// Depth-entry valid/ready buffer that registers both directions of the
// handshake: ready_o, valid_o and data_o come only from flops, so no
// combinational path crosses from one side of the block to the other.
module stream_cut_fifo
    import stream_cut_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2,
    parameter bit          Bypass    = 1'b0,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [AddrWidth:0]   usage_o
);

    if (Bypass) begin : g_bypass

        // Pure wire: no storage, flush and clock have nothing to act on.
        logic unused_bypass;
        assign unused_bypass = ^{clk_i, rst_ni, flush_i};

        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
        assign usage_o = '0;

    end else begin : g_fifo

        logic [AddrWidth:0]   wr_ptr_q;
        logic [AddrWidth:0]   rd_ptr_q;
        logic                 full;
        logic                 empty;
        logic                 push;
        logic                 pop;
        logic [DataWidth-1:0] mem_d [Depth];
        logic [DataWidth-1:0] mem_q [Depth];

        assign full  = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), AddrWidth + 1);
        assign empty = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q), AddrWidth + 1);

        assign ready_o = !full;
        assign valid_o = !empty;
        assign data_o  = mem_q[rd_ptr_q[AddrWidth-1:0]];
        assign usage_o = wr_ptr_q - rd_ptr_q;

        // A flush cycle completes no handshake on either side.
        assign push = valid_i && ready_o && !flush_i;
        assign pop  = valid_o && ready_i && !flush_i;

        stream_cut_ptr #(
            .Width (AddrWidth + 1)
        ) u_wr_ptr (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (flush_i),
            .en_i    (push),
            .ptr_o   (wr_ptr_q)
        );

        stream_cut_ptr #(
            .Width (AddrWidth + 1)
        ) u_rd_ptr (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (flush_i),
            .en_i    (pop),
            .ptr_o   (rd_ptr_q)
        );

        // Storage next state: only the slot under the write pointer changes on a push.
        always_comb begin
            mem_d = mem_q;
            if (push) begin
                mem_d[wr_ptr_q[AddrWidth-1:0]] = data_i;
            end
        end

        // Storage array is deliberately not reset; valid_o masks stale contents.
        always_ff @(posedge clk_i) begin
            mem_q <= mem_d;
        end

`ifndef SYNTHESIS
        a_depth_pow2 : assert property (@(posedge clk_i)
            (Depth >= 2) && ((Depth & (Depth - 1)) == 0));
        a_width_min : assert property (@(posedge clk_i) DataWidth >= 1);
        a_usage_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
            32'(usage_o) <= Depth);
        a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (full && !flush_i) |=> $stable(wr_ptr_q));
        a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o)));
`endif

    end

endmodule
